// File: rtl/mul_pkg.sv
// mul_pkg: shared FSM encoding and default latency/tag width for the multiplier slice
package mul_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;
  localparam int MUL_LATENCY = 33;
  localparam int TAG_W = 4;
endpackage

// File: rtl/mul_sequencer.sv
// mul_sequencer: issues requests to the sequential Booth multiplier, counts its latency and returns the product
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int TAG_W = mul_pkg::TAG_W,
  parameter int MUL_LATENCY = mul_pkg::MUL_LATENCY,
  parameter bit ZERO_BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic [WIDTH-1:0] mul_result,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);
  localparam int CW = MUL_LATENCY > 1 ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_LATENCY - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [TAG_W-1:0] tag_q;
  logic accept, zero_op, done;
  assign req_ready = (state == IDLE && !rst) || (state == RESP && resp_ready);
  assign accept = req_valid && req_ready;
  assign zero_op = ZERO_BYPASS && (req_a == '0 || req_b == '0);
  assign done = state == WAIT && cnt == '0;
  assign mul_start = state == START;
  assign resp_valid = state == RESP;
  assign busy = state != IDLE;
  assign resp_tag = tag_q;
  // next state: accepts in IDLE or on a completing response, bypassing the multiplier for zero operands
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? (zero_op ? RESP : START) : IDLE;
      START:   state_n = WAIT;
      WAIT:    state_n = done ? RESP : WAIT;
      RESP:    state_n = accept ? (zero_op ? RESP : START) : (resp_ready ? IDLE : RESP);
      default: state_n = IDLE;
    endcase
  end
  // state register; reset abandons any in-flight operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // operand/tag capture, latency down-counter and product capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a <= '0;
      mul_b <= '0;
      tag_q <= '0;
      cnt <= '0;
      resp_result <= '0;
    end else begin
      if (accept) begin
        mul_a <= req_a;
        mul_b <= req_b;
        tag_q <= req_tag;
      end
      if (accept && zero_op) resp_result <= '0;
      else if (done) resp_result <= mul_result;
      cnt <= state == START ? CNT_LOAD : (state == WAIT && cnt != '0) ? cnt - CW'(1) : cnt;
    end
  end
endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Upstream issue/capture stage for the sequential 64-bit Booth radix-4 multiplier block.
- Accepts multiply requests over a valid/ready handshake and holds the operands stable.
- Drives the multiplier's start (reset-style) pulse and counts the fixed multiplier latency.
- Captures the product and presents it downstream over a second valid/ready handshake. It also provides a zero-operand bypass and a tag passthrough.

Parameters:
- WIDTH, 64, operand and result width.
- TAG_W, 4, width of the request/response tag.
- MUL_LATENCY, 33, cycles from the falling edge of mul_start until mul_result is valid. Must be at least 1.
- ZERO_BYPASS, 1, when 1, a request with a zero operand completes without starting the multiplier.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_a  in  WIDTH  multiplicand, two's complement.
- req_b  in  WIDTH  multiplier, two's complement.
- req_tag  in  TAG_W  opaque request identifier.
- mul_start  out  1  one-cycle pulse wired to the multiplier's rst input.
- mul_a  out  WIDTH  held operand to the multiplier's a input.
- mul_b  out  WIDTH  held operand to the multiplier's b input.
- mul_result  in  WIDTH  multiplier out; sampled only at capture.
- resp_valid  out  1  result available.
- resp_ready  in  1  downstream accepts the result.
- resp_result  out  WIDTH  captured product, low WIDTH bits.
- resp_tag  out  TAG_W  tag of the completed request.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: asynchronous, active-high. While rst is high, state=IDLE, the latency counter is 0 and every output is 0, including req_ready and mul_start. After reset deasserts, req_ready is 1 from the first clock edge.
- States: IDLE, START, WAIT, RESP; encoding comes from the package.
- IDLE: req_ready=1. A handshake (req_valid && req_ready) latches req_a/req_b into mul_a/mul_b and req_tag into the tag register.
  - If ZERO_BYPASS=1 and either operand is 0: go to RESP with resp_result=0. mul_start is never asserted.
  - Otherwise: go to START.
- START: mul_start=1 for exactly one cycle. Counter loads MUL_LATENCY-1. Go to WAIT.
- WAIT: counter decrements each cycle. When counter==0, capture mul_result into resp_result and go to RESP.
- Operand stability: mul_a and mul_b stay constant from the accept edge until the next accept. The multiplier samples them while its rst input is high.
- Latency (non-bypass): accept at edge T, so mul_start is high in cycle T+1. Capture occurs at edge T+1+MUL_LATENCY, and resp_valid is first high at T+2+MUL_LATENCY (35 cycles with the default).
- Latency (bypass): resp_valid is high one cycle after accept.
- RESP: resp_valid=1. resp_result and resp_tag are held stable until resp_ready is sampled high; they must not change while resp_valid && !resp_ready.
- RESP and req_ready: req_ready = resp_ready in this state, i.e. combinational pass-through for back-to-back issue.
  - Response and request handshake in the same cycle: the new request is handled exactly as in IDLE (go to START or bypass to RESP).
  - Response handshake only: go to IDLE.
- req_ready is 0 in START and WAIT. Requests presented then are ignored and must be held by the source.
- Arithmetic: no sign handling here; the product sign comes from the multiplier. Result is the low WIDTH bits only, with no overflow flag.
- Reset mid-operation (any state): the operation is abandoned, no response is issued and the tag is discarded. mul_start stays 0 until a new accept.
- req_valid while rst is high is ignored.

Decomposition:
- Shared package mul_pkg holds:
  - state typedef/localparams (IDLE, START, WAIT, RESP);
  - default MUL_LATENCY = 33;
  - default TAG_W = 4.
- The multiplier block reuses MUL_LATENCY from the same package.
- No sub-module; the latency counter is a small inline down-counter.

Test Plan:
- req_a=3, req_b=5, tag=0x2, resp_ready=1 -> mul_start pulses once in cycle T+1; resp_valid at T+35 with resp_result=0xF, resp_tag=0x2; busy low the following cycle.
- req_a=req_b=0xFFFFFFFFFFFFFFFD (-3) -> resp_result=0x0000000000000009 after 35 cycles.
- req_a=0, req_b=0x1234 -> mul_start never asserts; resp_valid=1, resp_result=0 one cycle after accept.
- Result ready, resp_ready held 0 for 10 cycles -> resp_valid, resp_result and resp_tag stay stable and req_ready=0 throughout; on resp_ready=1 they clear or advance.
- Two queued requests (2x7 tag 1, 4x4 tag 2) with resp_ready=1 -> second accepted in the same cycle as first response; responses 0xE/tag 1 then 0x10/tag 2, 35 cycles apart.
- rst pulsed 10 cycles into WAIT -> all outputs 0 immediately (asynchronous); no response ever issued for that request; next request 6x7 completes with 0x2A.
